// File: rtl/seq_multiplier_pkg.sv
// Shared encodings for the iterative RV32M multiplier: op codes (also used by
// decode), FSM state encodings and operand signedness helpers.
package seq_multiplier_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } mul_state_e;

  // MUL low half is sign-independent, so it runs unsigned like MULHU.
  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/ripple_carry_adder_Nb.sv
// N-bit ripple-carry adder with optional B inversion; shared datapath block.
module ripple_carry_adder_Nb #(
  parameter int N = 32
) (
  input  logic [N-1:0] opa_i,
  input  logic [N-1:0] opb_i,
  input  logic         carry_i,
  input  logic         inv_b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N-1:0] w_b;
  logic         w_c;

  assign w_b = opb_i ^ {N{inv_b_i}};

  always_comb begin
    sum_o = '0;
    w_c   = carry_i;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = opa_i[i] ^ w_b[i] ^ w_c;
      w_c      = (opa_i[i] & w_b[i]) | (w_c & (opa_i[i] ^ w_b[i]));
    end
    carry_o = w_c;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier for MUL/MULH/MULHSU/MULHU: magnitudes are
// multiplied over N cycles, then the 2N-bit product is sign-fixed in one cycle.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] opa_i,
  input  logic [N-1:0] opb_i,
  input  logic         flush_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] res_o
);

  localparam int                CW       = $clog2(N);
  localparam logic [CW-1:0]     CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [N-1:0]      ONE_N    = N'(1);
  localparam logic [2*N-1:0]    ONE_2N   = (2 * N)'(1);

  mul_state_e     r_state;
  mul_state_e     w_state_nxt;
  logic [2*N-1:0] r_p;
  logic [N-1:0]   r_mcand;
  logic [1:0]     r_op;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_res;

  logic           w_accept;
  logic           w_calc_last;
  logic [N-1:0]   w_addend;
  logic [N-1:0]   w_sum;
  logic           w_carry;
  logic [2*N-1:0] w_p_fix;
  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic           w_neg_in;

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic is_signed);
    return (is_signed && v[N-1]) ? (~v + ONE_N) : v;
  endfunction

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign res_o       = r_res;
  assign w_accept    = valid_i && ready_o;
  assign w_calc_last = (r_cnt == CNT_LAST);

  assign w_a_mag  = magnitude(opa_i, op_a_signed(op_i));
  assign w_b_mag  = magnitude(opb_i, op_b_signed(op_i));
  assign w_neg_in = (op_i == MUL_OP_MULH)   ? (opa_i[N-1] ^ opb_i[N-1]) :
                    (op_i == MUL_OP_MULHSU) ? opa_i[N-1] : 1'b0;

  assign w_addend = r_p[0] ? r_mcand : '0;
  assign w_p_fix  = r_neg ? (~r_p + ONE_2N) : r_p;

  ripple_carry_adder_Nb #(.N(N)) u_adder (
    .opa_i   (r_p[2*N-1:N]),
    .opb_i   (w_addend),
    .carry_i (1'b0),
    .inv_b_i (1'b0),
    .sum_o   (w_sum),
    .carry_o (w_carry)
  );

  // Flush aborts anything in flight; in IDLE there is nothing to abort.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (valid_i)     w_state_nxt = S_CALC;
      S_CALC: if (w_calc_last) w_state_nxt = S_FIX;
      S_FIX:                   w_state_nxt = S_DONE;
      S_DONE: if (ready_i)     w_state_nxt = S_IDLE;
    endcase
    if (flush_i && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= '0;
        r_neg <= w_neg_in;
      end else if (r_state == S_CALC) begin
        r_cnt <= w_calc_last ? '0 : (r_cnt + CNT_ONE);
      end
      // Result register is loaded only on FIX->DONE and is zero elsewhere.
      if ((r_state == S_FIX) && !flush_i)
        r_res <= (r_op == MUL_OP_MUL) ? w_p_fix[N-1:0] : w_p_fix[2*N-1:N];
      else if ((r_state == S_DONE) && (ready_i || flush_i))
        r_res <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mcand <= w_a_mag;
      r_p     <= {{N{1'b0}}, w_b_mag};
      r_op    <= op_i;
    end else if (r_state == S_CALC) begin
      r_p <= {w_carry, w_sum, r_p[N-1:1]};
    end else if (r_state == S_FIX) begin
      r_p <= w_p_fix;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: known products, latency, backpressure,
// flush and mid-operation reset.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] res_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  seq_multiplier #(.N(32)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one request at a negedge; returns at the negedge after acceptance.
  task automatic start_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    check({tag, "_ready_before"}, {31'd0, ready_o}, 32'd1);
    op_i = op; opa_i = a; opb_i = b; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Counts edges after acceptance until valid_o, bounded at 40.
  task automatic wait_result(output int edges, output logic saw_ready);
    edges = 0;
    saw_ready = 1'b0;
    while (!valid_o && edges < 40) begin
      if (ready_o) saw_ready = 1'b1;
      @(negedge clk_i);
      edges++;
    end
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, "_res"}, res_o, exp);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check({tag, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    check({tag, "_res_cleared"}, res_o, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int   edges;
    logic saw_ready;
    start_op(tag, op, a, b);
    wait_result(edges, saw_ready);
    check({tag, "_latency"}, edges, 32'd33);
    finish_op(tag, exp);
  endtask

  initial begin
    int   edges;
    logic saw_ready;
    logic saw_valid;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_res", res_o, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Cycle t+34 begins 33 edges after the accepting edge t.
    start_op("mul7x6", MUL_OP_MUL, 32'd7, 32'd6);
    check("mul7x6_ready_low_t1", {31'd0, ready_o}, 32'd0);
    wait_result(edges, saw_ready);
    check("mul7x6_latency", edges, 32'd33);
    check("mul7x6_ready_stays_low", {31'd0, saw_ready}, 32'd0);
    finish_op("mul7x6", 32'h0000_002A);

    run_op("mulh_min_min",  MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulh_m1_x1",    MUL_OP_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op("mulhu_ff_ff",   MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_ff_ff",  MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_ff_ff",     MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mulh_min_zero", MUL_OP_MULH,   32'h8000_0000, 32'h0000_0000, 32'h0000_0000);

    start_op("bp", MUL_OP_MUL, 32'h1234_5678, 32'h0000_0010);
    wait_result(edges, saw_ready);
    check("bp_latency", edges, 32'd33);
    for (int i = 0; i < 5; i++) begin
      valid_i = i[0];
      opa_i   = 32'd9;
      opb_i   = 32'd9;
      @(negedge clk_i);
      check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
      check("bp_hold_res", res_o, 32'h2345_6780);
      check("bp_hold_ready", {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    finish_op("bp", 32'h2345_6780);

    start_op("flush", MUL_OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_ready", {31'd0, ready_o}, 32'd1);
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) saw_valid = 1'b1;
      @(negedge clk_i);
    end
    check("flush_no_result", {31'd0, saw_valid}, 32'd0);

    start_op("rst_mid", MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    check("rst_mid_ready", {31'd0, ready_o}, 32'd1);
    check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
    check("rst_mid_res", res_o, 32'd0);
    @(negedge clk_i);

    run_op("mul3x5", MUL_OP_MUL, 32'd3, 32'd5, 32'h0000_000F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
